// File: rtl/msi_vector_arbiter_pkg.sv
// Shared types and AXI constants for the MSI vector arbiter.
package msi_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AW   = 2'd1,
      S_W    = 2'd2,
      S_B    = 2'd3
   } state_t;

   // MSI write marker carried on AWUSER toward the PCIe controller.
   localparam logic [87:0] AWUSER_MSI  = {1'b1, 31'b0, 32'b0, 24'h000002};
   localparam logic [2:0]  AWSIZE_256B = 3'h5;
   localparam logic [1:0]  BRESP_OKAY  = 2'b00;

endpackage

// File: rtl/msi_vector_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: first request at or above i_ptr wins, wrapping.
module rr_arbiter #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt_onehot,
   output logic [IW-1:0] o_gnt_idx,
   output logic          o_gnt_valid
);

   always_comb begin
      int idx;
      idx          = 0;
      o_gnt_onehot = '0;
      o_gnt_idx    = '0;
      o_gnt_valid  = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = int'(i_ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!o_gnt_valid && i_req[idx]) begin
            o_gnt_valid       = 1'b1;
            o_gnt_idx         = IW'(idx);
            o_gnt_onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/msi_vector_arbiter.sv
// Multi-vector MSI scheduler: edge-captured pending bits, round-robin grant,
// one single-beat AXI write (AW, W, B) per grant.
//
// state  | meaning
// S_IDLE | arbitrating among eligible pending vectors
// S_AW   | write address presented, waiting for AWREADY
// S_W    | single data beat presented, waiting for WREADY
// S_B    | waiting for the write response
module msi_vector_arbiter
   import msi_pkg::*;
#(
   parameter int         NUM_VEC    = 8,
   parameter logic [7:0] AXI_ID     = 8'h00,
   parameter int         SENT_CNT_W = 32,
   parameter int         VEC_W      = $clog2(NUM_VEC)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NUM_VEC-1:0]    i_irq_req,
   input  logic [NUM_VEC-1:0]    i_vec_mask,
   input  logic                  i_msi_enable,
   input  logic [31:0]           i_msi_addr,
   input  logic [15:0]           i_msi_data,
   output logic [63:0]           o_awaddr,
   output logic [7:0]            o_awid,
   output logic [7:0]            o_awlen,
   output logic [2:0]            o_awsize,
   output logic [87:0]           o_awuser,
   output logic                  o_awvalid,
   input  logic                  i_awready,
   output logic [255:0]          o_wdata,
   output logic [31:0]           o_wstrb,
   output logic                  o_wlast,
   output logic                  o_wvalid,
   input  logic                  i_wready,
   input  logic [7:0]            i_bid,
   input  logic [1:0]            i_bresp,
   input  logic                  i_bvalid,
   output logic                  o_bready,
   output logic [NUM_VEC-1:0]    o_pending,
   output logic                  o_busy,
   output logic [15:0]           o_err_cnt,
   output logic [SENT_CNT_W-1:0] o_sent_cnt
);

   state_t                  r_state, w_state_nxt;
   logic [NUM_VEC-1:0]      r_irq_d, r_pending;
   logic [NUM_VEC-1:0]      w_edge, w_eligible, w_inflight, w_clr, w_gnt_onehot;
   logic [VEC_W-1:0]        r_rr_ptr, r_vec, w_gnt_idx;
   logic [31:0]             r_addr;
   logic [15:0]             r_data, w_wsum;
   logic [15:0]             r_err_cnt;
   logic [SENT_CNT_W-1:0]   r_sent_cnt;
   logic                    w_gnt_valid, w_grant, w_b_hs, w_b_ok;
   logic                    w_unused;

   assign w_edge     = i_irq_req & ~r_irq_d;
   assign w_inflight = (r_state != S_IDLE) ? ({{(NUM_VEC-1){1'b0}}, 1'b1} << r_vec) : '0;
   assign w_eligible = r_pending & ~i_vec_mask & ~w_inflight;

   rr_arbiter #(
      .N  (NUM_VEC),
      .IW (VEC_W)
   ) u_rr_arbiter (
      .i_req        (w_eligible),
      .i_ptr        (r_rr_ptr),
      .o_gnt_onehot (w_gnt_onehot),
      .o_gnt_idx    (w_gnt_idx),
      .o_gnt_valid  (w_gnt_valid)
   );

   assign w_grant = (r_state == S_IDLE) && i_msi_enable && w_gnt_valid;
   assign w_b_hs  = (r_state == S_B) && i_bvalid;
   assign w_b_ok  = w_b_hs && (i_bresp == BRESP_OKAY);
   // A same-cycle edge on the completing vector re-sets pending after the clear.
   assign w_clr   = w_b_ok ? w_inflight : '0;
   assign w_wsum  = r_data + {{(16-VEC_W){1'b0}}, r_vec};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_awvalid   = 1'b0;
      o_awaddr    = '0;
      o_awid      = '0;
      o_awlen     = '0;
      o_awsize    = '0;
      o_awuser    = '0;
      o_wvalid    = 1'b0;
      o_wlast     = 1'b0;
      o_wdata     = '0;
      o_wstrb     = '0;
      o_bready    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_grant) w_state_nxt = S_AW;
         end
         S_AW: begin
            o_awvalid = 1'b1;
            o_awaddr  = {32'b0, r_addr};
            o_awid    = AXI_ID;
            o_awsize  = AWSIZE_256B;
            o_awuser  = AWUSER_MSI;
            if (i_awready) w_state_nxt = S_W;
         end
         S_W: begin
            o_wvalid = 1'b1;
            o_wlast  = 1'b1;
            o_wdata  = {240'b0, w_wsum} << {r_addr[4:0], 3'b000};
            o_wstrb  = 32'h3 << r_addr[4:0];
            if (i_wready) w_state_nxt = S_B;
         end
         S_B: begin
            o_bready = 1'b1;
            if (i_bvalid) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_irq_d    <= '0;
         r_pending  <= '0;
         r_rr_ptr   <= '0;
         r_vec      <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_err_cnt  <= '0;
         r_sent_cnt <= '0;
      end else begin
         r_irq_d   <= i_irq_req;
         r_pending <= (r_pending & ~w_clr) | w_edge;
         if (w_grant) begin
            r_vec    <= w_gnt_idx;
            r_rr_ptr <= (w_gnt_idx == VEC_W'(NUM_VEC-1)) ? '0 : w_gnt_idx + 1'b1;
            r_addr   <= i_msi_addr;
            r_data   <= i_msi_data;
         end
         if (w_b_ok)
            r_sent_cnt <= r_sent_cnt + 1'b1;
         else if (w_b_hs && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign o_pending  = r_pending;
   assign o_busy     = (r_state != S_IDLE);
   assign o_err_cnt  = r_err_cnt;
   assign o_sent_cnt = r_sent_cnt;

   assign w_unused = ^{i_bid, w_gnt_onehot};

endmodule

// File: tb/tb_msi_vector_arbiter.sv
// Scoreboard bench for msi_vector_arbiter: directed interrupt scenarios with
// a reactive AXI slave and a monitor checking every AW/W beat against a queue.
module tb_msi_vector_arbiter;

   localparam int NV = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [NV-1:0] i_irq_req, i_vec_mask;
   logic          i_msi_enable;
   logic [31:0]   i_msi_addr;
   logic [15:0]   i_msi_data;
   logic [63:0]   o_awaddr;
   logic [7:0]    o_awid, o_awlen;
   logic [2:0]    o_awsize;
   logic [87:0]   o_awuser;
   logic          o_awvalid, i_awready;
   logic [255:0]  o_wdata;
   logic [31:0]   o_wstrb;
   logic          o_wlast, o_wvalid, i_wready;
   logic [7:0]    i_bid;
   logic [1:0]    i_bresp;
   logic          i_bvalid, o_bready;
   logic [NV-1:0] o_pending;
   logic          o_busy;
   logic [15:0]   o_err_cnt;
   logic [31:0]   o_sent_cnt;

   always #5 clk = ~clk;

   msi_vector_arbiter #(.NUM_VEC(NV), .AXI_ID(8'h00), .SENT_CNT_W(32)) dut (
      .clk(clk), .rstn(rstn),
      .i_irq_req(i_irq_req), .i_vec_mask(i_vec_mask), .i_msi_enable(i_msi_enable),
      .i_msi_addr(i_msi_addr), .i_msi_data(i_msi_data),
      .o_awaddr(o_awaddr), .o_awid(o_awid), .o_awlen(o_awlen), .o_awsize(o_awsize),
      .o_awuser(o_awuser), .o_awvalid(o_awvalid), .i_awready(i_awready),
      .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
      .i_wready(i_wready),
      .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
      .o_pending(o_pending), .o_busy(o_busy), .o_err_cnt(o_err_cnt), .o_sent_cnt(o_sent_cnt)
   );

   typedef struct {
      logic [63:0]  awaddr;
      logic [255:0] wdata;
      logic [31:0]  wstrb;
   } exp_t;

   exp_t       sb_q[$];
   logic [1:0] bresp_q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         aw_stall = 0;
   bit         w_hold = 1'b0;
   bit         b_manual = 1'b0;
   int         aw_cyc = 0;
   int         last_aw_cyc = 0;
   bit         aw_hs = 1'b0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [63:0] a, input logic [255:0] d, input logic [31:0] s);
      exp_t e;
      e.awaddr = a;
      e.wdata  = d;
      e.wstrb  = s;
      sb_q.push_back(e);
   endtask

   task automatic pulse(input logic [NV-1:0] v);
      @(negedge clk);
      i_irq_req = v;
      @(negedge clk);
      @(negedge clk);
      i_irq_req = '0;
   endtask

   task automatic wait_idle(input string name);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(o_busy == 1'b0 && sb_q.size() == 0) && cyc < 300);
      chk({name, "_timeout"}, 256'(cyc >= 300), 256'd0);
   endtask

   task automatic wait_sig(input string name, input bit want_w);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(want_w ? o_wvalid : o_bready) && cyc < 100);
      chk({name, "_timeout"}, 256'(cyc >= 100), 256'd0);
   endtask

   // Reactive AXI slave; inputs change 1ns after the rising edge.
   initial begin
      i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00; i_bid = 8'h5A;
      forever begin
         @(posedge clk);
         #1;
         if (o_awvalid && aw_stall > 0) begin
            aw_stall--;
            i_awready = 1'b0;
         end else begin
            i_awready = 1'b1;
         end
         i_wready = !w_hold;
         if (!b_manual) begin
            if (o_bready && !i_bvalid) begin
               i_bvalid = 1'b1;
               i_bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
            end else begin
               i_bvalid = 1'b0;
               i_bresp  = 2'b00;
            end
         end
      end
   end

   // Monitor: AW fields checked on every valid cycle, W beat pops the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            aw_hs  = 1'b0;
            aw_cyc = 0;
         end else begin
            if (o_awvalid) begin
               aw_cyc++;
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL aw_unexpected: got awaddr %0h expected no write", o_awaddr);
               end else begin
                  chk("aw_fields", 256'({o_awaddr, o_awid, o_awlen, o_awsize, o_awuser}),
                      256'({sb_q[0].awaddr, 8'h00, 8'h00, 3'h5, 88'h80000000_00000000_000002}));
               end
               if (i_awready) aw_hs = 1'b1;
            end
            if (o_wvalid && i_wready) begin
               chk("w_after_aw", 256'({aw_hs, o_awvalid}), 256'(2'b10));
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL w_unexpected: got wdata %0h expected no write", o_wdata);
               end else begin
                  chk("wdata", o_wdata, sb_q[0].wdata);
                  chk("wstrb", 256'(o_wstrb), 256'(sb_q[0].wstrb));
                  chk("wlast", 256'(o_wlast), 256'd1);
                  void'(sb_q.pop_front());
               end
               last_aw_cyc = aw_cyc;
               aw_cyc      = 0;
               aw_hs       = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      i_irq_req    = '0;
      i_vec_mask   = '0;
      i_msi_enable = 1'b1;
      i_msi_addr   = 32'h0000_1004;
      i_msi_data   = 16'h0040;
      rstn         = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valids", 256'({o_awvalid, o_wvalid, o_wlast, o_bready, o_busy}), 256'd0);
      chk("rst_aw", 256'({o_awaddr, o_awsize, o_awuser}), 256'd0);
      chk("rst_w", o_wdata | 256'(o_wstrb), 256'd0);
      chk("rst_state", 256'({o_pending, o_err_cnt, o_sent_cnt}), 256'd0);
      rstn = 1'b1;
      @(negedge clk);

      // Single edge on vector 3, checking the two-cycle edge-to-AWVALID latency.
      push_exp(64'h1004, 256'h43 << 32, 32'h30);
      i_irq_req = 8'h08;
      @(negedge clk);
      chk("t1_pending_set", 256'(o_pending), 256'h08);
      chk("t1_no_aw_yet", 256'(o_awvalid), 256'd0);
      @(negedge clk);
      chk("t1_awvalid", 256'(o_awvalid), 256'd1);
      i_irq_req = '0;
      wait_idle("t1");
      chk("t1_pending_clr", 256'(o_pending), 256'd0);
      chk("t1_sent", 256'(o_sent_cnt), 256'd1);
      chk("t1_err", 256'(o_err_cnt), 256'd0);

      // Reset so the round-robin pointer restarts at 0.
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("mid_rst_sent", 256'(o_sent_cnt), 256'd0);
      rstn = 1'b1;

      // Simultaneous edges on 1, 5, 6, then 7 and 0 (search resumes at 7 and wraps).
      i_msi_addr = 32'h0000_2010;
      push_exp(64'h2010, 256'h41 << 128, 32'h0003_0000);
      push_exp(64'h2010, 256'h45 << 128, 32'h0003_0000);
      push_exp(64'h2010, 256'h46 << 128, 32'h0003_0000);
      pulse(8'b0110_0010);
      wait_idle("t2a");
      push_exp(64'h2010, 256'h47 << 128, 32'h0003_0000);
      push_exp(64'h2010, 256'h40 << 128, 32'h0003_0000);
      pulse(8'b1000_0001);
      wait_idle("t2b");
      chk("t2_sent", 256'(o_sent_cnt), 256'd5);
      chk("t2_pending", 256'(o_pending), 256'd0);

      // AWREADY low 10 cycles; inputs changed mid-transaction must not leak through.
      i_msi_addr = 32'h0000_301E;
      i_msi_data = 16'hFFFE;
      aw_stall   = 10;
      push_exp(64'h301E, 256'h4 << 240, 32'hC000_0000);
      pulse(8'h40);
      i_msi_addr = 32'hDEAD_0000;
      i_msi_data = 16'h1234;
      wait_idle("t3");
      chk("t3_aw_cycles", 256'(last_aw_cyc), 256'd11);
      chk("t3_sent", 256'(o_sent_cnt), 256'd6);
      i_msi_addr = 32'h0000_1004;
      i_msi_data = 16'h0040;

      // SLVERR on vector 2, then retry completes OKAY.
      bresp_q.push_back(2'b10);
      push_exp(64'h1004, 256'h42 << 32, 32'h30);
      push_exp(64'h1004, 256'h42 << 32, 32'h30);
      pulse(8'h04);
      wait_sig("t4_bready", 1'b0);
      @(negedge clk);
      chk("t4_err_after_slverr", 256'(o_err_cnt), 256'd1);
      chk("t4_pending_kept", 256'(o_pending), 256'h04);
      chk("t4_sent_unchanged", 256'(o_sent_cnt), 256'd6);
      wait_idle("t4");
      chk("t4_pending_clr", 256'(o_pending), 256'd0);
      chk("t4_sent", 256'(o_sent_cnt), 256'd7);
      chk("t4_err", 256'(o_err_cnt), 256'd1);

      // Masked vector 4 stays pending until the mask is cleared.
      i_vec_mask = 8'h10;
      pulse(8'h10);
      repeat (8) @(negedge clk);
      chk("t5_masked_pending", 256'(o_pending), 256'h10);
      chk("t5_masked_idle", 256'({o_busy, o_awvalid}), 256'd0);
      push_exp(64'h1004, 256'h44 << 32, 32'h30);
      i_vec_mask = '0;
      @(negedge clk);
      chk("t5_grant_next_cycle", 256'({o_busy, o_awvalid}), 256'(2'b11));
      wait_idle("t5");
      chk("t5_pending_clr", 256'(o_pending), 256'd0);
      chk("t5_sent", 256'(o_sent_cnt), 256'd8);

      // New edge on vector 0 captured in the same cycle as its OKAY response.
      push_exp(64'h1004, 256'h40 << 32, 32'h30);
      push_exp(64'h1004, 256'h40 << 32, 32'h30);
      b_manual = 1'b1;
      pulse(8'h01);
      wait_sig("t6_bready", 1'b0);
      i_bvalid  = 1'b1;
      i_bresp   = 2'b00;
      i_irq_req = 8'h01;
      @(negedge clk);
      i_bvalid  = 1'b0;
      i_irq_req = '0;
      b_manual  = 1'b0;
      chk("t6_pending_kept", 256'(o_pending), 256'h01);
      chk("t6_sent_first", 256'(o_sent_cnt), 256'd9);
      wait_idle("t6");
      chk("t6_pending_clr", 256'(o_pending), 256'd0);
      chk("t6_sent", 256'(o_sent_cnt), 256'd10);

      // Reset asserted while the W beat is stalled.
      w_hold = 1'b1;
      push_exp(64'h1004, 256'h45 << 32, 32'h30);
      pulse(8'h20);
      wait_sig("t7_wvalid", 1'b1);
      chk("t7_pending_before", 256'(o_pending), 256'h20);
      rstn = 1'b0;
      #1;
      chk("t7_rst_valids", 256'({o_wvalid, o_bready, o_awvalid, o_busy}), 256'd0);
      chk("t7_rst_pending", 256'(o_pending), 256'd0);
      sb_q.delete();
      w_hold = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("t7_idle_after", 256'({o_busy, o_awvalid, o_wvalid}), 256'd0);
      chk("t7_counters", 256'({o_sent_cnt, o_err_cnt}), 256'd0);
      push_exp(64'h1004, 256'h45 << 32, 32'h30);
      pulse(8'h20);
      wait_idle("t7");
      chk("t7_sent", 256'(o_sent_cnt), 256'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
